// File: rtl/if_id_pipe_reg_pkg.sv
// Shared encodings for the IF->ID pipeline register: control polarities and FSM states.
package if_id_pipe_reg_pkg;
   localparam logic FLUSH_ON = 1'b1;
   localparam logic STALL_ON = 1'b1;

   typedef enum logic [1:0] {
      PIPE_EMPTY = 2'b00,
      PIPE_ONE   = 2'b01,
      PIPE_FULL  = 2'b10
   } pipe_state_t;
endpackage

// File: rtl/if_id_pipe_reg_slot.sv
// One valid+payload register; clear zeroes everything, load captures, drop only invalidates.
module pipe_skid_slot #(
   parameter int W = 68
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         load,
   input  logic         drop,
   input  logic [W-1:0] d,
   output logic         valid,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (clear) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (load) begin
         valid <= 1'b1;
         q     <= d;
      end else if (drop) begin
         // payload kept so id_* show the last beat after a drain
         valid <= 1'b0;
      end
   end
endmodule

// File: rtl/if_id_pipe_reg.sv
// IF->ID pipeline register with a 2-entry skid buffer and a registered upstream ready.
// Optional perf counters (stall cycles, flushed beats) under IF_ID_PERF_EN.
module if_id_pipe_reg
   import if_id_pipe_reg_pkg::*;
#(
   parameter int PC_W   = 32,
   parameter int INST_W = 32,
   parameter int SIDE_W = 4
`ifdef IF_ID_PERF_EN
   ,
   parameter int CNT_W  = 32
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              stall,
   input  logic              if_valid,
   output logic              if_ready,
   input  logic [PC_W-1:0]   if_pc,
   input  logic [INST_W-1:0] if_inst,
   input  logic [SIDE_W-1:0] if_side,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [PC_W-1:0]   id_pc,
   output logic [INST_W-1:0] id_inst,
   output logic [SIDE_W-1:0] id_side
`ifdef IF_ID_PERF_EN
   ,
   output logic [CNT_W-1:0]  perf_stall,
   output logic [CNT_W-1:0]  perf_flush
`endif
);
   localparam int BEAT_W = PC_W + INST_W + SIDE_W;

   pipe_state_t       state, state_nxt;
   logic              main_valid, skid_valid;
   logic [BEAT_W-1:0] main_q, skid_q, in_beat, main_d;
   logic              clear, main_load, main_from_skid, main_drop, skid_load, skid_drop;
   logic              up_xfer, dn_take, dn_xfer;

   assign in_beat  = {if_pc, if_inst, if_side};
   assign if_ready = ~skid_valid;
   assign up_xfer  = if_valid & if_ready;
   assign dn_take  = id_ready & (stall != STALL_ON);
   assign dn_xfer  = main_valid & dn_take;
   assign clear    = (flush == FLUSH_ON);
   assign main_d   = main_from_skid ? skid_q : in_beat;

   always_comb begin
      state_nxt      = state;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      main_drop      = 1'b0;
      skid_load      = 1'b0;
      skid_drop      = 1'b0;
      if (clear) begin
         state_nxt = PIPE_EMPTY;
      end else begin
         case (state)
            PIPE_EMPTY: begin
               if (up_xfer) begin
                  main_load = 1'b1;
                  state_nxt = PIPE_ONE;
               end
            end
            PIPE_ONE: begin
               if (up_xfer && dn_xfer) begin
                  main_load = 1'b1;
               end else if (up_xfer && !dn_take) begin
                  skid_load = 1'b1;
                  state_nxt = PIPE_FULL;
               end else if (dn_xfer) begin
                  main_drop = 1'b1;
                  state_nxt = PIPE_EMPTY;
               end
            end
            PIPE_FULL: begin
               if (dn_xfer) begin
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
                  skid_drop      = 1'b1;
                  state_nxt      = PIPE_ONE;
               end
            end
            default: state_nxt = PIPE_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= PIPE_EMPTY;
      else        state <= state_nxt;
   end

   pipe_skid_slot #(.W(BEAT_W)) u_main (
      .clk(clk), .rst_n(rst_n), .clear(clear), .load(main_load), .drop(main_drop),
      .d(main_d), .valid(main_valid), .q(main_q)
   );

   pipe_skid_slot #(.W(BEAT_W)) u_skid (
      .clk(clk), .rst_n(rst_n), .clear(clear), .load(skid_load), .drop(skid_drop),
      .d(in_beat), .valid(skid_valid), .q(skid_q)
   );

   assign id_valid                  = main_valid;
   assign {id_pc, id_inst, id_side} = main_q;

`ifdef IF_ID_PERF_EN
   logic [1:0] flush_beats;
   assign flush_beats = {1'b0, main_valid} + {1'b0, skid_valid};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall <= '0;
         perf_flush <= '0;
      end else begin
         if (main_valid && !dn_take) perf_stall <= perf_stall + CNT_W'(1);
         if (clear)                  perf_flush <= perf_flush + CNT_W'(flush_beats);
      end
   end
`endif
endmodule
